// File: rtl/pixel_fetch_arbiter.sv
// Frame-buffer pixel fetcher: credit-limited raster reads into a small
// word FIFO, sharing the single SRAM port with drawing-engine writes.
module pixel_fetch_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 2,
  parameter int ADDR_W     = 18
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              FRAME_START,
  input  logic              PIXEL_REQ,
  output logic [7:0]        PIXEL_OUT,
  output logic              PIXEL_VALID,
  output logic              UNDERRUN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [15:0]       MEM_WDATA,
  input  logic [15:0]       MEM_RDATA,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [15:0]       WR_DATA,
  output logic              WR_GNT
);

  localparam int NWORDS = H_ACTIVE * V_ACTIVE / 2;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int LW     = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NWORDS - 1);
  localparam logic [LW-1:0]     HALF = LW'(FIFO_DEPTH / 2);
  localparam logic [LW-1:0]     FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_addr;
  logic [RD_LAT-1:0] rd_pipe;
  logic [15:0]       fifo [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [LW-1:0]     occ, inflight, level;
  logic              hi_sel;
  logic              do_rd, do_wr;
  logic              push, pop, avail;

  // Reads count as in flight from the strobe until their data lands.
  always_comb begin
    inflight = LW'(MEM_RD);
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + LW'(rd_pipe[i]);
  end

  assign level = occ + inflight;
  assign avail = (occ != '0);
  assign push  = rd_pipe[RD_LAT-1] && !FRAME_START;
  assign pop   = PIXEL_REQ && !FRAME_START && avail && hi_sel;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (FRAME_START)
      state_nx = FETCH;
    else if (state == FETCH && do_rd && rd_addr == LAST)
      state_nx = DRAIN;
  end

  // Low watermark reads beat writes; writes never granted back to back.
  always_comb begin
    do_rd = 1'b0;
    do_wr = 1'b0;
    if (!FRAME_START) begin
      if (state == FETCH) begin
        if (level < HALF)              do_rd = 1'b1;
        else if (WR_REQ && !WR_GNT)    do_wr = 1'b1;
        else if (level < FULL)         do_rd = 1'b1;
      end else begin
        do_wr = WR_REQ && !WR_GNT;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MEM_RD    <= 1'b0;
      MEM_WR    <= 1'b0;
      WR_GNT    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      rd_addr   <= '0;
      rd_pipe   <= '0;
    end else begin
      MEM_RD <= do_rd;
      MEM_WR <= do_wr;
      WR_GNT <= do_wr;
      if (do_rd) begin
        MEM_ADDR <= rd_addr;
      end else if (do_wr) begin
        MEM_ADDR  <= WR_ADDR;
        MEM_WDATA <= WR_DATA;
      end
      if (FRAME_START)  rd_addr <= '0;
      else if (do_rd)   rd_addr <= rd_addr + 1'b1;
      if (FRAME_START)  rd_pipe <= '0;
      else              rd_pipe <= RD_LAT'({rd_pipe, MEM_RD});
    end
  end

  always_ff @(posedge Clk) begin
    if (push) fifo[wp] <= MEM_RDATA;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wp          <= '0;
      rp          <= '0;
      occ         <= '0;
      hi_sel      <= 1'b0;
      PIXEL_OUT   <= '0;
      PIXEL_VALID <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else if (FRAME_START) begin
      wp          <= '0;
      rp          <= '0;
      occ         <= '0;
      hi_sel      <= 1'b0;
      PIXEL_VALID <= 1'b0;
      UNDERRUN    <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
      PIXEL_VALID <= 1'b0;
      if (PIXEL_REQ) begin
        if (avail) begin
          PIXEL_OUT   <= hi_sel ? fifo[rp][15:8] : fifo[rp][7:0];
          PIXEL_VALID <= 1'b1;
          hi_sel      <= ~hi_sel;
        end else begin
          PIXEL_OUT <= 8'h00;
          UNDERRUN  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_fetch_arbiter.sv
// Scoreboard bench for pixel_fetch_arbiter on a reduced 16x4 frame
// (32 words) with an SRAM model returning the word address as data.
module tb_pixel_fetch_arbiter;

  localparam int AW = 18;
  localparam int NW = 32;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          FRAME_START = 1'b0;
  logic          PIXEL_REQ = 1'b0;
  logic [7:0]    PIXEL_OUT;
  logic          PIXEL_VALID;
  logic          UNDERRUN;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_RD;
  logic          MEM_WR;
  logic [15:0]   MEM_WDATA;
  logic [15:0]   MEM_RDATA;
  logic          WR_REQ = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [15:0]   WR_DATA = '0;
  logic          WR_GNT;

  pixel_fetch_arbiter #(
    .H_ACTIVE(16), .V_ACTIVE(4), .FIFO_DEPTH(8), .RD_LAT(2), .ADDR_W(AW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .FRAME_START(FRAME_START),
    .PIXEL_REQ(PIXEL_REQ), .PIXEL_OUT(PIXEL_OUT),
    .PIXEL_VALID(PIXEL_VALID), .UNDERRUN(UNDERRUN),
    .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_GNT(WR_GNT)
  );

  always #5 Clk = ~Clk;

  // SRAM: data = address, two cycles after the address is presented
  logic [15:0] d1 = '0, d2 = '0;
  always @(posedge Clk) begin
    d1 <= MEM_ADDR[15:0];
    d2 <= d1;
  end
  assign MEM_RDATA = d2;

  int n_pass = 0;
  int n_total = 0;
  int rd_cnt = 0;
  int base;
  logic prev_gnt = 1'b0;
  logic [AW-1:0]    exp_rd[$];
  logic [7:0]       exp_pix[$];
  logic [AW+15:0]   exp_wr[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_fs();
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
  endtask

  task automatic push_rd(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_rd.push_back(AW'(a));
  endtask

  task automatic push_frame_pix();
    for (int w = 0; w < NW; w++) begin
      logic [15:0] wd;
      wd = 16'(w);
      exp_pix.push_back(wd[7:0]);
      exp_pix.push_back(wd[15:8]);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d);
    bit got;
    exp_wr.push_back({a, d});
    WR_ADDR = a;
    WR_DATA = d;
    WR_REQ  = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (WR_GNT) got = 1;
    end
    check("wr_gnt_seen", got, 1);
  endtask

  task automatic monitor();
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (MEM_RD) begin
          rd_cnt++;
          check("rd_no_wr", MEM_WR, 0);
          check("rd_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) check("rd_addr", MEM_ADDR, exp_rd.pop_front());
        end
        if (MEM_WR) begin
          check("wr_gnt_with_wr", WR_GNT, 1);
          check("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0)
            check("wr_addr_data", {MEM_ADDR, MEM_WDATA}, exp_wr.pop_front());
        end
        if (WR_GNT) check("no_double_gnt", prev_gnt, 0);
        prev_gnt = WR_GNT;
        if (PIXEL_VALID) begin
          check("pix_expected", exp_pix.size() != 0, 1);
          if (exp_pix.size() != 0) check("pix_out", PIXEL_OUT, exp_pix.pop_front());
        end
      end
    end
  endtask

  task automatic stimulus();
    repeat (3) tick();
    check("reset_outs",
          {PIXEL_OUT, PIXEL_VALID, UNDERRUN, MEM_ADDR, MEM_RD, MEM_WR,
           MEM_WDATA, WR_GNT}, '0);
    Reset = 1'b0;
    tick();

    // fill with no consumption: exactly 8 reads
    push_rd(0, 7);
    base = rd_cnt;
    pulse_fs();
    repeat (20) tick();
    check("a_fill_reads", rd_cnt - base, 8);

    // stream the whole frame, one request per cycle
    push_rd(8, NW - 1);
    push_frame_pix();
    PIXEL_REQ = 1'b1;
    repeat (2 * NW) tick();
    PIXEL_REQ = 1'b0;
    repeat (10) tick();
    check("b_frame_reads", rd_cnt - base, NW);
    check("b_no_underrun", UNDERRUN, 0);
    check("b_pix_drained", exp_pix.size(), 0);

    // writes with FIFO full
    push_rd(0, 7);
    pulse_fs();
    repeat (14) tick();
    do_write(18'h2A5A5, 16'hBEEF);
    do_write(18'h00155, 16'h1234);
    do_write(18'h3FFFF, 16'hC3C3);
    WR_REQ = 1'b0;
    repeat (4) tick();
    check("e_wr_done", exp_wr.size(), 0);

    // empty FIFO: urgent reads win until level reaches 4
    push_rd(0, 8);
    base = rd_cnt;
    pulse_fs();
    do_write(18'h01234, 16'h5A5A);
    check("f_urgent_reads", rd_cnt - base, 4);
    WR_REQ = 1'b0;
    repeat (15) tick();
    exp_pix.push_back(8'h00);
    exp_pix.push_back(8'h00);
    exp_pix.push_back(8'h01);
    PIXEL_REQ = 1'b1;
    repeat (3) tick();
    PIXEL_REQ = 1'b0;
    repeat (8) tick();
    check("f_reads", rd_cnt - base, 9);
    check("f_last_pix", PIXEL_OUT, 8'h01);

    // request before any data returns
    push_rd(0, 7);
    pulse_fs();
    check("c_underrun_clear", UNDERRUN, 0);
    PIXEL_REQ = 1'b1;
    tick();
    PIXEL_REQ = 1'b0;
    check("c_underrun_resp", {PIXEL_VALID, PIXEL_OUT, UNDERRUN}, {1'b0, 8'h00, 1'b1});
    repeat (15) tick();
    check("c_underrun_sticky", UNDERRUN, 1);

    // restart with two reads in flight, then a full frame
    exp_rd.push_back(AW'(0));
    exp_rd.push_back(AW'(1));
    push_rd(0, NW - 1);
    base = rd_cnt;
    pulse_fs();
    check("d_underrun_cleared", UNDERRUN, 0);
    tick();
    tick();
    check("d_two_in_flight", rd_cnt - base, 1);
    pulse_fs();
    repeat (14) tick();
    push_frame_pix();
    PIXEL_REQ = 1'b1;
    repeat (2 * NW) tick();
    PIXEL_REQ = 1'b0;
    repeat (10) tick();
    check("d_frame_reads", rd_cnt - base, NW + 2);
    check("d_rd_drained", exp_rd.size(), 0);
    check("d_pix_drained", exp_pix.size(), 0);
    check("d_no_underrun", UNDERRUN, 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
